// File: rtl/input_row_buffer_if.sv
// Sender write port and router read port of the input row buffer.
// Widths follow the buffer geometry; derived widths have a floor of one bit.
interface input_row_buffer_if #(
    parameter int DW   = 32,
    parameter int POY  = 3,
    parameter int BUFW = 32,
    parameter int BUFH = 2
);
    localparam int BW = (POY  > 1) ? $clog2(POY)  : 1;
    localparam int RW = (BUFH > 1) ? $clog2(BUFH) : 1;
    localparam int CW = (BUFW > 1) ? $clog2(BUFW) : 1;

    logic                    wvalid;
    logic                    wready;
    logic [DW-1:0]           wdata;
    logic [BW-1:0]           wbank;
    logic [RW-1:0]           wrow;
    logic [CW-1:0]           wcol;

    logic                    rreq;
    logic                    rready;
    logic [1:0]              rpsel;
    logic [BW-1:0]           rbank;
    logic [RW-1:0]           rrow;
    logic [CW-1:0]           rcol;
    logic                    rrel;
    logic [POY*BUFW*DW-1:0]  rdata;
    logic                    rvalid;
    logic [POY*BUFH-1:0]     row_valid;
    logic                    err;

    modport master (
        output wvalid, wdata, wbank, wrow, wcol,
        output rreq, rpsel, rbank, rrow, rcol, rrel,
        input  wready, rready, rdata, rvalid, row_valid, err
    );

    modport slave (
        input  wvalid, wdata, wbank, wrow, wcol,
        input  rreq, rpsel, rbank, rrow, rcol, rrel,
        output wready, rready, rdata, rvalid, row_valid, err
    );
endinterface

// File: rtl/input_row_buffer.sv
// Banked input row buffer with per-row fill/release tracking and RR/BR/RP/NE reads.
// Define INPUT_ROW_BUFFER_ERR_EN to consume out-of-range requests and raise a sticky err.
module input_row_buffer #(
    parameter int DW   = 32,
    parameter int POY  = 3,
    parameter int BUFW = 32,
    parameter int BUFH = 2
) (
    input logic                clk,
    input logic                rst_n,
    input_row_buffer_if.slave  bus
);
    localparam int BW  = (POY  > 1) ? $clog2(POY)  : 1;
    localparam int RW  = (BUFH > 1) ? $clog2(BUFH) : 1;
    localparam int CW  = (BUFW > 1) ? $clog2(BUFW) : 1;
    localparam int RVW = POY * BUFH;
    localparam int RDW = POY * BUFW * DW;

    typedef enum logic [1:0] {
        M_RR = 2'b00,
        M_BR = 2'b01,
        M_RP = 2'b10,
        M_NE = 2'b11
    } rmode_e;

    rmode_e          mode;
    logic [DW-1:0]   mem_q [POY][BUFH][BUFW];
    logic [RVW-1:0]  rv_q;
    logic [RVW-1:0]  rv_d;
    logic [RDW-1:0]  rdata_q;
    logic [RDW-1:0]  rdata_d;
    logic            rvalid_q;
    logic            rvalid_d;
    logic            w_sel_valid;
    logic            r_all;
    logic            r_one;
    logic            w_oob;
    logic            r_oob;
    logic            wready;
    logic            rready;
    logic            wacc;
    logic            racc;
    logic            rupd;

    assign mode = rmode_e'(bus.rpsel);

    always_comb begin
        w_sel_valid = 1'b0;
        r_all       = 1'b1;
        r_one       = 1'b0;
        for (int i = 0; i < POY; i++) begin
            for (int r = 0; r < BUFH; r++) begin
                if (BW'(i) == bus.wbank && RW'(r) == bus.wrow)
                    w_sel_valid = rv_q[i*BUFH+r];
                if (RW'(r) == bus.rrow) begin
                    r_all = r_all & rv_q[i*BUFH+r];
                    if (BW'(i) == bus.rbank)
                        r_one = rv_q[i*BUFH+r];
                end
            end
        end
    end

`ifdef INPUT_ROW_BUFFER_ERR_EN
    assign w_oob = (int'(bus.wbank) >= POY)
                || (int'(bus.wrow) >= BUFH)
                || (int'(bus.wcol) >= BUFW);
    assign r_oob = (mode != M_NE)
                && ((int'(bus.rrow) >= BUFH)
                 || (mode == M_BR && int'(bus.rbank) >= POY));
`else
    assign w_oob = 1'b0;
    assign r_oob = 1'b0;
`endif

    // Out-of-range requests are consumed so the requester never deadlocks.
    always_comb begin
        rready = 1'b0;
        unique case (mode)
            M_RR, M_RP: rready = r_all;
            M_BR:       rready = r_one;
            M_NE:       rready = 1'b1;
            default:    rready = 1'b0;
        endcase
        rready = rready | r_oob;
    end

    assign wready = w_oob | ~w_sel_valid;
    assign wacc   = bus.wvalid & wready & ~w_oob;
    assign racc   = bus.rreq & rready;
    assign rupd   = racc & ~r_oob & (mode != M_NE);

    always_ff @(posedge clk) begin
        if (wacc) begin
            for (int i = 0; i < POY; i++)
                for (int r = 0; r < BUFH; r++)
                    for (int c = 0; c < BUFW; c++)
                        if (BW'(i) == bus.wbank && RW'(r) == bus.wrow
                            && CW'(c) == bus.wcol)
                            mem_q[i][r][c] <= bus.wdata;
        end
    end

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        rv_d     = rv_q;
        if (rupd) begin
            rvalid_d = 1'b1;
            for (int i = 0; i < POY; i++) begin
                for (int r = 0; r < BUFH; r++) begin
                    if (RW'(r) == bus.rrow) begin
                        for (int j = 0; j < BUFW; j++) begin
                            if (mode == M_RR
                                || (mode == M_BR && BW'(i) == bus.rbank)
                                || (mode == M_RP && CW'(j) == bus.rcol))
                                rdata_d[(i*BUFW+j)*DW +: DW] = mem_q[i][r][j];
                        end
                        if (bus.rrel && (mode != M_BR || BW'(i) == bus.rbank))
                            rv_d[i*BUFH+r] = 1'b0;
                    end
                end
            end
        end
        // A read never targets the row being completed, so set after clear is safe.
        if (wacc && bus.wcol == CW'(BUFW-1)) begin
            for (int i = 0; i < POY; i++)
                for (int r = 0; r < BUFH; r++)
                    if (BW'(i) == bus.wbank && RW'(r) == bus.wrow)
                        rv_d[i*BUFH+r] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv_q     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rv_q     <= rv_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef INPUT_ROW_BUFFER_ERR_EN
    logic err_q;
    logic err_d;

    always_comb begin
        err_d = err_q;
        if ((bus.wvalid && w_oob) || (bus.rreq && r_oob))
            err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.wready    = wready;
    assign bus.rready    = rready;
    assign bus.rdata     = rdata_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.row_valid = rv_q;
endmodule

// File: tb/tb_input_row_buffer.sv
// Directed bench for input_row_buffer with a reference model and read scoreboard.
// Builds with or without INPUT_ROW_BUFFER_ERR_EN.
module tb_input_row_buffer;
    localparam int DW   = 8;
    localparam int POY  = 3;
    localparam int BUFW = 4;
    localparam int BUFH = 2;

    logic clk;
    logic rst_n;

    input_row_buffer_if #(.DW(DW), .POY(POY), .BUFW(BUFW), .BUFH(BUFH)) bus ();

    input_row_buffer #(.DW(DW), .POY(POY), .BUFW(BUFW), .BUFH(BUFH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mm [3][2][4];
    logic [95:0] rd_m;
    logic [5:0]  rv_m;
    logic [95:0] sbq [$];
    int          total;
    int          bad;

    task automatic chk(input string tag, input logic [127:0] o,
                       input logic [127:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic idle();
        bus.wvalid = 1'b0;
        bus.wdata  = '0;
        bus.wbank  = '0;
        bus.wrow   = '0;
        bus.wcol   = '0;
        bus.rreq   = 1'b0;
        bus.rpsel  = '0;
        bus.rbank  = '0;
        bus.rrow   = '0;
        bus.rcol   = '0;
        bus.rrel   = 1'b0;
    endtask

    task automatic wr(input int b, input int r, input int c,
                      input logic [7:0] d, input logic er);
        bus.wvalid = 1'b1;
        bus.wbank  = 2'(b);
        bus.wrow   = 1'(r);
        bus.wcol   = 2'(c);
        bus.wdata  = d;
        @(negedge clk);
        chk("wready", 128'(bus.wready), 128'(er));
        @(posedge clk);
        #1;
        bus.wvalid = 1'b0;
        if (er) begin
            mm[b][r][c] = d;
            if (c == 3) rv_m[b*2+r] = 1'b1;
        end
        chk("row_valid_wr", 128'(bus.row_valid), 128'(rv_m));
    endtask

    task automatic rd(input int m, input int b, input int r, input int c,
                      input logic rel, input logic er);
        bus.rreq  = 1'b1;
        bus.rpsel = 2'(m);
        bus.rbank = 2'(b);
        bus.rrow  = 1'(r);
        bus.rcol  = 2'(c);
        bus.rrel  = rel;
        @(negedge clk);
        chk("rready", 128'(bus.rready), 128'(er));
        if (er && m != 3) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 4; j++)
                    if (m == 0 || (m == 1 && i == b) || (m == 2 && j == c))
                        rd_m[(i*4+j)*8 +: 8] = mm[i][r][j];
            sbq.push_back(rd_m);
        end
        @(posedge clk);
        #1;
        bus.rreq = 1'b0;
        bus.rrel = 1'b0;
        if (er && rel && m != 3)
            for (int i = 0; i < 3; i++)
                if (m != 1 || i == b) rv_m[i*2+r] = 1'b0;
        chk("rvalid", 128'(bus.rvalid), 128'(er && m != 3));
        if (bus.rvalid) begin
            chk("sb_has_entry", 128'(sbq.size() != 0), 128'(1));
            if (sbq.size() != 0)
                chk("rdata", 128'(bus.rdata), 128'(sbq.pop_front()));
        end else begin
            chk("rdata_hold", 128'(bus.rdata), 128'(rd_m));
        end
        chk("row_valid_rd", 128'(bus.row_valid), 128'(rv_m));
    endtask

    initial begin
        logic [7:0] tmp;
        total = 0;
        bad   = 0;
        rd_m  = '0;
        rv_m  = '0;
        idle();
        rst_n = 1'b0;
        #2;
        chk("rst_rdata", 128'(bus.rdata), 128'(0));
        chk("rst_rvalid", 128'(bus.rvalid), 128'(0));
        chk("rst_row_valid", 128'(bus.row_valid), 128'(0));
        chk("rst_err", 128'(bus.err), 128'(0));
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int b = 0; b < 3; b++)
            for (int c = 0; c < 4; c++) begin
                tmp = 8'((b << 4) | c);
                wr(b, 0, c, tmp, 1'b1);
            end
        chk("fill_row0", 128'(bus.row_valid), 128'(6'b010101));
        rd(0, 0, 0, 0, 1'b0, 1'b1);
        chk("rr_b2w1", 128'(bus.rdata[(2*4+1)*8 +: 8]), 128'(8'h21));

        for (int c = 0; c < 4; c++) begin
            tmp = 8'(8'h90 + c);
            wr(1, 1, c, tmp, 1'b1);
        end
        rd(0, 0, 1, 0, 1'b0, 1'b0);
        rd(1, 1, 1, 0, 1'b0, 1'b1);
        chk("br_b0_kept", 128'(bus.rdata[31:0]), 128'(32'h03020100));

        wr(0, 0, 0, 8'h55, 1'b0);
        mm[0][0][2] = 8'h02;
        rd(2, 0, 0, 2, 1'b0, 1'b1);
        chk("rp_b1w3_kept", 128'(bus.rdata[(1*4+3)*8 +: 8]), 128'(8'h93));

        rd(0, 0, 0, 0, 1'b1, 1'b1);
        chk("release_row0", 128'(bus.row_valid), 128'(6'b001000));
        wr(0, 0, 3, 8'hAA, 1'b1);
        chk("reuse_row0", 128'(bus.row_valid), 128'(6'b001001));

        for (int c = 0; c < 3; c++) begin
            tmp = 8'(8'h60 + c);
            wr(0, 1, c, tmp, 1'b1);
        end
        bus.wvalid = 1'b1;
        bus.wbank  = 2'd0;
        bus.wrow   = 1'b1;
        bus.wcol   = 2'd3;
        bus.wdata  = 8'h63;
        bus.rreq   = 1'b1;
        bus.rpsel  = 2'b01;
        bus.rbank  = 2'd0;
        bus.rrow   = 1'b1;
        bus.rrel   = 1'b0;
        @(negedge clk);
        chk("sim_wready", 128'(bus.wready), 128'(1));
        chk("sim_rready", 128'(bus.rready), 128'(0));
        @(posedge clk);
        #1;
        bus.wvalid = 1'b0;
        bus.rreq   = 1'b0;
        mm[0][1][3] = 8'h63;
        rv_m[1]     = 1'b1;
        chk("sim_rvalid", 128'(bus.rvalid), 128'(0));
        rd(1, 0, 1, 0, 1'b0, 1'b1);
        chk("sim_newword", 128'(bus.rdata[31:24]), 128'(8'h63));

        rd(3, 0, 0, 0, 1'b1, 1'b1);

        wr(2, 1, 0, 8'hE0, 1'b1);
        wr(2, 1, 1, 8'hE1, 1'b1);
        rd(1, 1, 1, 0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_row_valid", 128'(bus.row_valid), 128'(0));
        chk("mid_rvalid", 128'(bus.rvalid), 128'(0));
        chk("mid_rdata", 128'(bus.rdata), 128'(0));
        chk("mid_err", 128'(bus.err), 128'(0));
        rd_m = '0;
        rv_m = '0;
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wr(2, 1, 0, 8'hF0, 1'b1);

`ifdef INPUT_ROW_BUFFER_ERR_EN
        bus.wvalid = 1'b1;
        bus.wbank  = 2'd3;
        bus.wrow   = 1'b0;
        bus.wcol   = 2'd0;
        bus.wdata  = 8'h77;
        @(negedge clk);
        chk("oob_wready", 128'(bus.wready), 128'(1));
        @(posedge clk);
        #1;
        bus.wvalid = 1'b0;
        chk("oob_err", 128'(bus.err), 128'(1));
        chk("oob_row_valid", 128'(bus.row_valid), 128'(rv_m));
        @(posedge clk);
        #1;
        chk("err_sticky", 128'(bus.err), 128'(1));
`else
        chk("err_tied", 128'(bus.err), 128'(0));
`endif

        chk("sb_drained", 128'(sbq.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
